// File: rtl/sync_fifo_arb_pkg.sv
// Shared types and constants for the sync_fifo_cnt write-port arbiter.
//   arb_state_e : arbiter FSM states
//   ARB_STATS_W : width of each per-lane accepted-word counter
package sync_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_STATS_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Ports:
//   req_i        : request vector, one bit per lane
//   last_grant_i : lane granted most recently; scanning starts one past it
//   any_o        : at least one request is set
//   sel_o        : first requesting lane at last_grant_i+1, +2, ... (mod NUM_REQ)
module rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_grant_i,
  output logic               any_o,
  output logic [IW-1:0]      sel_o
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset to the nearest so the nearest hit wins.
  always_comb begin
    any_o = 1'b0;
    sel_o = '0;
    idx   = '0;
    for (int unsigned off = NUM_REQ; off > 0; off--) begin
      idx = IW'((32'(last_grant_i) + off) % NUM_REQ);
      if (req_i[idx]) begin
        any_o = 1'b1;
        sel_o = idx;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_wr_arb.sv
// Round-robin write arbiter sharing one sync_fifo_cnt write port among
// NUM_REQ valid/ready producers, granting bursts of up to BURST_LEN words.
// Optional feature: define SYNC_FIFO_WR_ARB_STATS_EN to add wr_count, one
// saturating 16-bit accepted-word counter per lane.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   req_valid     : per-lane word available
//   req_data      : packed lane words, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     : per-lane accept (combinational from state and fifo_full)
//   fifo_full     : FIFO full flag
//   fifo_cnt      : FIFO occupancy
//   fifo_wr_en    : FIFO write enable
//   fifo_data_in  : FIFO write data, zero when not writing
//   grant_id      : granted lane, meaningful while busy
//   busy          : a burst grant is active
//   wr_count      : (optional) per-lane accepted-word counters, packed
module sync_fifo_wr_arb
  import sync_fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DATA_DEPTH = 8,
  parameter  int unsigned BURST_LEN  = 4,
  localparam int unsigned IW         = $clog2(NUM_REQ),
  localparam int unsigned CW         = $clog2(DATA_DEPTH) + 1,
  localparam int unsigned BW         = $clog2(BURST_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  input  logic [CW-1:0]                 fifo_cnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [IW-1:0]                 grant_id,
  output logic                          busy
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*ARB_STATS_W-1:0] wr_count
`endif
);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic            pick_any;
  logic [IW-1:0]   pick_sel;
  logic            lane_valid;
  logic [DATA_WIDTH-1:0] lane_data;
  logic            can_take;
  logic            xfer;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .any_o        (pick_any),
    .sel_o        (pick_sel)
  );

  // Granted-lane mux; only meaningful while in GRANT.
  always_comb begin
    lane_valid = 1'b0;
    lane_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IW'(i)) begin
        lane_valid = req_valid[i];
        lane_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Ready never looks at req_valid, keeping valid->ready free of a comb path.
  assign can_take = (state_q == ARB_GRANT) & ~fifo_full & (beat_cnt_q < BW'(BURST_LEN));
  assign xfer     = can_take & lane_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Next state and write-port outputs.
  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any && (fifo_cnt < CW'(DATA_DEPTH))) begin
          grant_id_d = pick_sel;
          beat_cnt_d = '0;
          state_d    = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = can_take & (grant_id_q == IW'(i));
        end
        fifo_wr_en   = xfer;
        fifo_data_in = xfer ? lane_data : '0;
        // A full stall with valid held keeps the grant and freezes the count.
        if (!lane_valid) begin
          state_d      = ARB_IDLE;
          last_grant_d = grant_id_q;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_id_q;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == ARB_GRANT);

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [NUM_REQ-1:0][ARB_STATS_W-1:0] wr_count_q, wr_count_d;

  // Saturating per-lane accepted-word counters.
  always_comb begin
    wr_count_d = wr_count_q;
    if (xfer && (wr_count_q[grant_id_q] != '1)) begin
      wr_count_d[grant_id_q] = wr_count_q[grant_id_q] + ARB_STATS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wr_count_q <= '0;
    else     wr_count_q <= wr_count_d;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// Self-checking bench for sync_fifo_wr_arb: a queue-based FIFO and producer
// model around the DUT, a burst-level arbitration model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo_wr_arb;
  import sync_fifo_arb_pkg::*;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int DD = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready;
  logic          fifo_full = 1'b0;
  logic [3:0]    fifo_cnt = '0;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;
  logic [1:0]    grant_id;
  logic          busy;
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
  logic [NR*ARB_STATS_W-1:0] wr_count;
`endif

  sync_fifo_wr_arb #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .DATA_DEPTH(DD), .BURST_LEN(BL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_cnt     (fifo_cnt),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    ,
    .wr_count     (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Producers
  bit        p_valid [NR];
  logic [7:0] p_data [NR];
  int        p_left  [NR];
  bit        p_rand  = 0;

  // FIFO model and write log
  logic [7:0] fq[$];
  logic [7:0] log_data[$];
  int         log_cyc[$];
  int         pop_pct  = 0;
  bit         pop_once = 0;

  // Burst-level arbitration model
  int m_owner = -1;
  int m_taken = 0;
  int m_prev  = NR - 1;

  bit         act_we;
  logic [7:0] act_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = p_valid[i];
      req_data[i*DW +: DW]  = p_data[i];
    end
    fifo_cnt  = 4'(fq.size());
    fifo_full = (fq.size() == DD);
  endtask

  task automatic load(input int lane, input int n, input logic [7:0] base);
    p_left[lane]  = n;
    p_data[lane]  = base;
    p_valid[lane] = (n > 0);
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_taken = 0;
    m_prev  = NR - 1;
  endtask

  // Compare DUT outputs with what the burst model says for this cycle.
  task automatic check_cycle();
    bit            full;
    logic [NR-1:0] e_rdy;
    bit            e_we;
    logic [7:0]    e_data;
    full   = (fq.size() == DD);
    e_rdy  = '0;
    e_we   = 0;
    e_data = '0;
    if (m_owner >= 0 && !full) begin
      e_rdy[m_owner] = 1'b1;
      e_we           = p_valid[m_owner];
      if (e_we) e_data = p_data[m_owner];
    end
    chk("busy", 64'(busy), 64'(m_owner >= 0));
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("fifo_wr_en", 64'(fifo_wr_en), 64'(e_we));
    chk("fifo_data_in", 64'(fifo_data_in), 64'(e_data));
    if (m_owner >= 0) chk("grant_id", 64'(grant_id), 64'(m_owner));
    act_we   = fifo_wr_en;
    act_data = fifo_data_in;
  endtask

  task automatic advance(input int l);
    if (p_rand) begin
      p_valid[l] = ($urandom_range(99) < 70);
      p_data[l]  = 8'($urandom);
    end else begin
      p_left[l]--;
      p_data[l]  = p_data[l] + 8'd1;
      p_valid[l] = (p_left[l] > 0);
    end
  endtask

  // One clock: check at negedge, update models at posedge, drive after.
  task automatic step();
    bit full;
    bit pop_now;
    int xl;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    full = (fq.size() == DD);
    xl   = -1;
    if (m_owner < 0) begin
      if (req_valid != '0 && fq.size() < DD) begin
        for (int k = 1; k <= NR; k++) begin
          int l;
          l = (m_prev + k) % NR;
          if (req_valid[l]) begin
            m_owner = l;
            break;
          end
        end
        m_taken = 0;
      end
    end else if (req_valid[m_owner]) begin
      if (!full) begin
        xl = m_owner;
        m_taken++;
        if (m_taken == BL) begin
          m_prev  = m_owner;
          m_owner = -1;
        end
      end
    end else begin
      m_prev  = m_owner;
      m_owner = -1;
    end
    pop_now  = (fq.size() > 0) && (pop_once || ($urandom_range(99) < pop_pct));
    pop_once = 0;
    if (act_we) begin
      chk("write_while_full", 64'(full), 64'd0);
      if (!full) fq.push_back(act_data);
      log_data.push_back(act_data);
      log_cyc.push_back(cyc);
    end
    if (pop_now) void'(fq.pop_front());
    if (xl >= 0) advance(xl);
    if (p_rand) begin
      for (int i = 0; i < NR; i++) begin
        if (i != xl && !p_valid[i] && $urandom_range(99) < 25) begin
          p_valid[i] = 1;
          p_data[i]  = 8'($urandom);
        end
      end
    end
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Reset with every lane requesting: all outputs must stay 0.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '1;
    req_data  = 32'hA5A5_A5A5;
    fifo_full = 1'b0;
    fifo_cnt  = '0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_wr_en", 64'(fifo_wr_en), 64'd0);
    chk("rst_data", 64'(fifo_data_in), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    chk("rst_wr_count", 64'(wr_count), 64'd0);
`endif
    p_rand = 0;
    for (int i = 0; i < NR; i++) load(i, 0, 8'h00);
    fq.delete();
    log_data.delete();
    log_cyc.delete();
    pop_pct = 0;
    model_reset();
    drive();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset priority: lane 0 first, one bubble, then lane 2.
    do_reset();
    load(0, 4, 8'h10);
    load(2, 4, 8'h20);
    drive();
    run(12);
    chk("prio_count", 64'(log_data.size()), 64'd8);
    if (log_data.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        chk("prio_lane0_word", 64'(log_data[k]), 64'(8'h10 + k));
        chk("prio_lane2_word", 64'(log_data[k+4]), 64'(8'h20 + k));
      end
      chk("prio_bubble", 64'(log_cyc[4] - log_cyc[3]), 64'd2);
    end

    // Rotation: 20 words with all lanes busy, FIFO drained concurrently.
    do_reset();
    load(0, 8, 8'h00);
    load(1, 4, 8'h40);
    load(2, 4, 8'h80);
    load(3, 4, 8'hC0);
    pop_pct = 100;
    drive();
    run(35);
    chk("rot_count", 64'(log_data.size()), 64'd20);
    if (log_data.size() == 20) begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 20; k++) begin
        int b;
        b = k / 4;
        chk("rot_word", 64'(log_data[k]),
            64'(order[b] * 64 + ((b == 4) ? 4 : 0) + (k % 4)));
      end
    end

    // Full stall mid-burst of lane 1, released by one FIFO read.
    do_reset();
    for (int k = 0; k < 5; k++) fq.push_back(8'hEE);
    load(1, 4, 8'h40);
    drive();
    run(9);
    chk("stall_words", 64'(log_data.size()), 64'd3);
    chk("stall_fifo_full", 64'(fq.size()), 64'(DD));
    chk("stall_busy", 64'(busy), 64'd1);
    chk("stall_grant", 64'(grant_id), 64'd1);
    chk("stall_ready", 64'(req_ready), 64'd0);
    pop_once = 1;
    run(4);
    chk("stall_done_words", 64'(log_data.size()), 64'd4);
    if (log_data.size() == 4) chk("stall_last_word", 64'(log_data[3]), 64'h43);
    chk("stall_done_busy", 64'(busy), 64'd0);

    // Early release by lane 3, then lane 0 wins over lane 2.
    do_reset();
    pop_pct = 100;
    load(1, 4, 8'h40);
    load(3, 2, 8'hC0);
    drive();
    for (int n = 0; n < 30 && m_owner != 3; n++) step();
    chk("early_busy", 64'(busy), 64'd1);
    chk("early_grant3", 64'(grant_id), 64'd3);
    load(0, 2, 8'h00);
    load(2, 2, 8'h80);
    drive();
    run(20);
    chk("early_count", 64'(log_data.size()), 64'd10);
    if (log_data.size() == 10) begin
      chk("early_l3_last", 64'(log_data[5]), 64'hC1);
      chk("early_next_l0", 64'(log_data[6]), 64'h00);
      chk("early_then_l2", 64'(log_data[8]), 64'h80);
    end

    // Asynchronous reset during lane 2's second word.
    do_reset();
    load(2, 4, 8'h80);
    drive();
    for (int n = 0; n < 20 && !(m_owner == 2 && m_taken == 1); n++) step();
    chk("arst_busy", 64'(busy), 64'd1);
    chk("arst_grant2", 64'(grant_id), 64'd2);
    @(negedge clk);
    check_cycle();
    chk("arst_pre_we", 64'(fifo_wr_en), 64'd1);
    chk("arst_pre_data", 64'(fifo_data_in), 64'h81);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy0", 64'(busy), 64'd0);
    chk("arst_ready0", 64'(req_ready), 64'd0);
    chk("arst_we0", 64'(fifo_wr_en), 64'd0);
    chk("arst_data0", 64'(fifo_data_in), 64'd0);
    chk("arst_grant0", 64'(grant_id), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    load(0, 2, 8'h00);
    drive();
    run(14);
    chk("arst_count", 64'(log_data.size()), 64'd6);
    if (log_data.size() == 6) begin
      chk("arst_first", 64'(log_data[0]), 64'h80);
      chk("arst_l0_first", 64'(log_data[1]), 64'h00);
      chk("arst_l2_resume", 64'(log_data[3]), 64'h81);
    end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
    // Per-lane accepted-word counters.
    do_reset();
    pop_pct = 100;
    load(1, 6, 8'h40);
    load(0, 3, 8'h00);
    drive();
    run(25);
    chk("stats_wr_count", 64'(wr_count), 64'h0000_0000_0006_0003);
`endif

    // Randomized traffic with random FIFO drain rates.
    do_reset();
    p_rand = 1;
    for (int blk = 0; blk < 12; blk++) begin
      pop_pct = $urandom_range(15, 100);
      run(250);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_wr_arb.md
# sync_fifo_wr_arb

Round-robin write arbiter that shares one `sync_fifo_cnt` write port among `NUM_REQ` producers. Each producer offers words on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` words and drives the FIFO's `wr_en`/`data_in` from the granted lane. It uses the FIFO's `full` and `fifo_cnt` outputs for back-pressure and sits directly in front of the FIFO write side.

## Interface
- `NUM_REQ`, 4: number of producers (≥2)
- `DATA_WIDTH`, 8: word width; must match FIFO
- `DATA_DEPTH`, 8: FIFO depth; must match FIFO
- `BURST_LEN`, 4: maximum words per grant (≥1)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  producer i has a word
- `req_data`  in  NUM_REQ*DATA_WIDTH  packed; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  NUM_REQ  word on lane i accepted this cycle when valid&ready
- `fifo_full`  in  1  FIFO `full`
- `fifo_cnt`  in  $clog2(DATA_DEPTH)+1  FIFO occupancy
- `fifo_wr_en`  out  1  to FIFO `wr_en`
- `fifo_data_in`  out  DATA_WIDTH  to FIFO `data_in`
- `grant_id`  out  $clog2(NUM_REQ)  currently granted lane (valid while `busy`)
- `busy`  out  1  state is GRANT

## Operation
- FSM has two states: IDLE and GRANT.
- Registered state: `last_grant`, `grant_id`, `beat_cnt` (width $clog2(BURST_LEN+1)).
- **IDLE:**
  - Grants when `|req_valid` and `fifo_cnt < DATA_DEPTH`.
  - Selects the first asserted lane scanning `last_grant+1, +2, …` modulo `NUM_REQ`.
  - Loads `grant_id`, clears `beat_cnt`, and moves to GRANT.
  - Otherwise stays in IDLE.
- **GRANT:**
  - `req_ready[grant_id] = ~fifo_full & (beat_cnt < BURST_LEN)`. All other ready bits are 0.
  - A transfer is `req_valid[grant_id] & req_ready[grant_id]`.
  - On a transfer: `fifo_wr_en=1`, `fifo_data_in` = lane `grant_id` slice, and `beat_cnt` increments.
- **Burst end (return to IDLE next edge, `last_grant <= grant_id`) occurs when either:**
  - a transfer makes `beat_cnt` reach `BURST_LEN`, or
  - `req_valid[grant_id]==0` in GRANT.
- **FIFO full during GRANT:**
  - Ready drops and the grant is held.
  - `beat_cnt` is frozen and the burst does not end on a stall.
- Simultaneous FIFO reads need no handling; only `fifo_full` gates writes.
- `fifo_wr_en` is never asserted while `fifo_full=1`, which prevents overflow.
- `fifo_data_in` is 0 when `fifo_wr_en=0`. It never passes a stale lane.

## Timing
- **Reset values (asynchronous, `rst=1`):**
  - IDLE; `grant_id=0`; `beat_cnt=0`.
  - `last_grant=NUM_REQ-1`, so lane 0 has first priority.
  - All outputs 0.
- **Reset mid-burst:** the burst is aborted immediately. Words already written stay in the FIFO, and no partial handshake completes.
- **Latency:** `req_valid` sampled high at edge k → GRANT after edge k → first write captured by the FIFO at edge k+1.
- The IDLE arbitration cycle is a one-cycle bubble between bursts.
- `req_ready` and `fifo_wr_en` are combinational from registered state and `fifo_full`. `fifo_wr_en` additionally depends on `req_valid`. There is no `req_valid`→`req_ready` combinational path.
- **Throughput:** `BURST_LEN` words per `BURST_LEN+1` cycles under continuous demand.
- **Handshake rule:** producers hold `req_valid` and `req_data` stable until accepted. A producer that drops `req_valid` forfeits the rest of its burst.

## Configuration
- `SYNC_FIFO_WR_ARB_STATS_EN`:
  - **Defined:** adds output `wr_count` (NUM_REQ*16, packed), one saturating 16-bit counter per lane that increments on each accepted word. It resets to 0 and holds at 16'hFFFF.
  - **Undefined:** no port and no counters. Behaviour is otherwise identical.

## Structure
- Package `sync_fifo_arb_pkg` holds:
  - the FSM state enum `arb_state_e` {ARB_IDLE, ARB_GRANT}
  - the stats counter width constant `ARB_STATS_W=16`
- Sub-module `rr_pick`: combinational round-robin selector taking (`req` vector, `last_grant`) and returning (`any`, `sel` index). It is instantiated once.
- Top level holds the FSM, burst counter, lane mux and optional stats.

## Test plan
- **Reset priority:** after reset, lanes 0 and 2 valid together with an empty FIFO → lane 0 gets 4 words (0x10–0x13), one bubble, then lane 2 gets 4 words. `grant_id` reads 0 then 2.
- **Rotation:** all 4 lanes continuously valid for 20 words → grant order 0,1,2,3,0. FIFO content is in burst order with the FIFO drained concurrently, and never more than 4 consecutive words from one lane.
- **Full stall:** 8 words fill the FIFO mid-burst of lane 1 → `req_ready` and `fifo_wr_en` stay 0 while full, `grant_id` stays 1, `beat_cnt` is frozen. After one FIFO read, the next word is written and the burst completes.
- **Early release:** lane 3 drops valid after 2 words → GRANT exits next edge, `last_grant=3`, and lane 0 is checked next.
- **Async reset mid-burst:** `rst` pulsed between edges during lane 2's second word → all outputs 0 immediately. After release, lane 0 has priority again.
- **Stats (macro defined):** 6 words on lane 1, 3 on lane 0 → `wr_count` lanes = {0,0,6,3}.
